// File: rtl/div_pkg.sv
// Shared definitions for the divide controller: state encoding, watchdog default
// and the {remainder, quotient} slice positions of the divider result.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    DONE   = 2'd2,
    CANCEL = 2'd3
  } div_state_e;

  localparam int DIV_MAX_CYCLES = 40;
  localparam int CANCEL_CYCLES  = 2;

  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  // Width of a counter able to hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Bundle of the EX-stage request, divider handshake and HI/LO result signals.
// slave is the controller's view; master is the view of the surrounding pipeline.
interface div_ctrl_if;

  logic        ex_div_i;
  logic        ex_signed_i;
  logic [31:0] ex_opa_i;
  logic [31:0] ex_opb_i;
  logic        flush_i;
  logic [63:0] div_result_i;
  logic        div_success_i;

  logic        div_start_o;
  logic        div_cancel_o;
  logic        div_signed_o;
  logic [31:0] div_opa_o;
  logic [31:0] div_opb_o;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;
  logic        zero_trap_o;

  modport slave (
    input  ex_div_i, ex_signed_i, ex_opa_i, ex_opb_i, flush_i,
           div_result_i, div_success_i,
    output div_start_o, div_cancel_o, div_signed_o, div_opa_o, div_opb_o,
           stall_o, hilo_we_o, hi_o, lo_o, timeout_o, zero_trap_o
  );

  modport master (
    output ex_div_i, ex_signed_i, ex_opa_i, ex_opb_i, flush_i,
           div_result_i, div_success_i,
    input  div_start_o, div_cancel_o, div_signed_o, div_opa_o, div_opb_o,
           stall_o, hilo_we_o, hi_o, lo_o, timeout_o, zero_trap_o
  );

endinterface

// File: rtl/div_wdog.sv
// Watchdog counter: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches limit.
module div_wdog #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;

  // cnt holds the number of earlier enabled cycles, so the limit-th cycle sees limit-1.
  assign expire = enable && !clear && (cnt == limit - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle divide controller between EX and an external divider.
// Optional macro DIV_CTRL_ZERO_TRAP_EN traps zero divisors instead of issuing them.
module div_ctrl
  import div_pkg::*;
#(
  parameter int MAX_CYCLES = DIV_MAX_CYCLES
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  localparam int             WD_W     = cnt_width(MAX_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_CYCLES);
  localparam logic [1:0]     CANCEL_LAST = 2'(CANCEL_CYCLES - 1);

  div_state_e  state, state_nxt;
  logic [1:0]  cancel_cnt;
  logic        signed_q;
  logic [31:0] opa_q, opb_q;
  logic [31:0] hi_q, lo_q;

  logic accept, zero_div, wd_expire;
  logic stall, start, cancel, hilo_we, timeout, load_op, load_hilo;

  // Reset has to win over a same-cycle request so every output reads 0 in reset.
  assign accept = !rst && (state == IDLE) && bus.ex_div_i && !bus.flush_i;

`ifdef DIV_CTRL_ZERO_TRAP_EN
  logic zero_trap_q;

  assign zero_div = (bus.ex_opb_i == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) zero_trap_q <= 1'b0;
    else     zero_trap_q <= accept && zero_div;
  end

  assign bus.zero_trap_o = zero_trap_q;
`else
  assign zero_div        = 1'b0;
  assign bus.zero_trap_o = 1'b0;
`endif

  div_wdog #(
    .W (WD_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != BUSY),
    .enable (state == BUSY),
    .limit  (WD_LIMIT),
    .expire (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cancel_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cancel_cnt <= (state == CANCEL) ? cancel_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    start     = 1'b0;
    cancel    = 1'b0;
    hilo_we   = 1'b0;
    timeout   = 1'b0;
    load_op   = 1'b0;
    load_hilo = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          load_op = 1'b1;
          if (!zero_div) state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        start = 1'b1;
        // A flush kills the divide even when the result arrives in the same cycle.
        if (bus.flush_i) begin
          state_nxt = CANCEL;
        end else if (bus.div_success_i) begin
          load_hilo = 1'b1;
          state_nxt = DONE;
        end else if (wd_expire) begin
          timeout   = 1'b1;
          state_nxt = CANCEL;
        end
      end
      DONE: begin
        hilo_we   = 1'b1;
        stall     = bus.ex_div_i;
        state_nxt = IDLE;
      end
      CANCEL: begin
        cancel = 1'b1;
        stall  = bus.ex_div_i;
        if (cancel_cnt == CANCEL_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      signed_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else if (load_op) begin
      signed_q <= bus.ex_signed_i;
      opa_q    <= bus.ex_opa_i;
      opb_q    <= bus.ex_opb_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (load_hilo) begin
      hi_q <= bus.div_result_i[HI_MSB:HI_LSB];
      lo_q <= bus.div_result_i[LO_MSB:LO_LSB];
    end
  end

  assign bus.stall_o      = stall;
  assign bus.div_start_o  = start;
  assign bus.div_cancel_o = cancel;
  assign bus.div_signed_o = signed_q;
  assign bus.div_opa_o    = opa_q;
  assign bus.div_opb_o    = opb_q;
  assign bus.hilo_we_o    = hilo_we;
  assign bus.hi_o         = hi_q;
  assign bus.lo_o         = lo_q;
  assign bus.timeout_o    = timeout;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed requests push expected HI/LO, a
// monitor pops and compares on every hilo_we_o; the divider is a scripted stub.
module tb_div_ctrl;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  div_ctrl_if bus();

  div_ctrl #(.MAX_CYCLES(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every HI/LO write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.hilo_we_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL hilo_unexpected actual=%h_%h required=no_write", bus.hi_o, bus.lo_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.hi_o !== e.hi || bus.lo_o !== e.lo) begin
          errors++;
          $display("FAIL hilo_value actual=%h_%h required=%h_%h", bus.hi_o, bus.lo_o, e.hi, e.lo);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, {bus.stall_o, bus.div_start_o, bus.div_cancel_o, bus.div_signed_o,
                         bus.hilo_we_o, bus.timeout_o, bus.zero_trap_o}, '0);
    chk({tag, "_opa"}, bus.div_opa_o, '0);
    chk({tag, "_opb"}, bus.div_opb_o, '0);
    chk({tag, "_hi"},  bus.hi_o, '0);
    chk({tag, "_lo"},  bus.lo_o, '0);
  endtask

  task automatic request(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.ex_div_i    = 1'b1;
    bus.ex_signed_i = sgn;
    bus.ex_opa_i    = a;
    bus.ex_opb_i    = b;
    #1 chk("accept_stall", bus.stall_o, 1'b1);
  endtask

  // Full divide: stub raises success on BUSY cycle lat with the given {hi, lo}.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] hi, input logic [31:0] lo);
    request(sgn, a, b);
    exp_q.push_back('{hi: hi, lo: lo});
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      bus.ex_div_i = 1'b0;
      chk("busy_start", bus.div_start_o, 1'b1);
      chk("busy_ops", {bus.div_signed_o, bus.div_opa_o, bus.div_opb_o}, {sgn, a, b});
      if (k == lat) begin
        bus.div_success_i = 1'b1;
        bus.div_result_i  = {hi, lo};
        #1 chk("busy_no_timeout", bus.timeout_o, 1'b0);
      end
    end
    @(negedge clk);
    bus.div_success_i = 1'b0;
    bus.div_result_i  = '0;
    chk("done_start", bus.div_start_o, 1'b0);
    chk("done_stall", bus.stall_o, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bus.ex_div_i      = 1'b0;
    bus.ex_signed_i   = 1'b0;
    bus.ex_opa_i      = '0;
    bus.ex_opb_i      = '0;
    bus.flush_i       = 1'b0;
    bus.div_result_i  = '0;
    bus.div_success_i = 1'b0;

    // Reset state, including a request held during reset.
    repeat (2) @(negedge clk);
    bus.ex_div_i = 1'b1;
    bus.ex_opa_i = 32'd3;
    bus.ex_opb_i = 32'd1;
    #1 check_all_zero("reset");
    bus.ex_div_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // DIVU 100/7 and DIV -100/7 (minimum latency).
    run_div(1'b0, 32'd100, 32'd7, 5, 32'd2, 32'd14);
    run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

    // Flush on BUSY cycle 10, request stalled during CANCEL, then DIVU 9/2.
    request(1'b0, 32'd50, 32'd3);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      bus.ex_div_i = 1'b0;
      if (k == 10) bus.flush_i = 1'b1;
    end
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_cancel1", bus.div_cancel_o, 1'b1);
    chk("flush_cancel1_start", bus.div_start_o, 1'b0);
    @(negedge clk);
    bus.ex_div_i = 1'b1;
    #1 chk("flush_cancel2", bus.div_cancel_o, 1'b1);
    chk("cancel_stall", bus.stall_o, 1'b1);
    @(negedge clk);
    bus.ex_div_i = 1'b0;
    chk("flush_cancel_end", bus.div_cancel_o, 1'b0);
    chk("cancel_no_accept", bus.div_start_o, 1'b0);
    chk("flush_hilo_held", {bus.hi_o, bus.lo_o}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    run_div(1'b0, 32'd9, 32'd2, 3, 32'd1, 32'd4);

    // Flush and success together: flush wins.
    request(1'b0, 32'd7, 32'd7);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.ex_div_i = 1'b0;
    end
    bus.flush_i       = 1'b1;
    bus.div_success_i = 1'b1;
    bus.div_result_i  = {32'hAAAA_AAAA, 32'h5555_5555};
    #1 chk("fs_no_timeout", bus.timeout_o, 1'b0);
    @(negedge clk);
    bus.flush_i       = 1'b0;
    bus.div_success_i = 1'b0;
    bus.div_result_i  = '0;
    chk("fs_cancel", bus.div_cancel_o, 1'b1);
    chk("fs_hilo_held", {bus.hi_o, bus.lo_o}, {32'd1, 32'd4});
    repeat (2) @(negedge clk);
    chk("fs_idle", bus.div_cancel_o, 1'b0);

    // Watchdog: no success, timeout on BUSY cycle 40, CANCEL for 2, IDLE.
    request(1'b0, 32'd1, 32'd1);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.ex_div_i = 1'b0;
      #1 chk($sformatf("wdog_timeout_c%0d", k), bus.timeout_o, (k == 40));
    end
    @(negedge clk);
    chk("wdog_cancel1", bus.div_cancel_o, 1'b1);
    chk("wdog_pulse_end", bus.timeout_o, 1'b0);
    @(negedge clk);
    chk("wdog_cancel2", bus.div_cancel_o, 1'b1);
    @(negedge clk);
    chk("wdog_idle", {bus.div_cancel_o, bus.div_start_o}, 2'b00);

    // Success on BUSY cycle 40 beats the watchdog; count restarted on entry.
    run_div(1'b0, 32'd1000, 32'd10, 40, 32'd0, 32'd100);

    // Reset during BUSY: everything to zero immediately, no write afterwards.
    request(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.ex_div_i = 1'b0;
    end
    rst = 1'b1;
    #1 check_all_zero("rst_busy");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle", {bus.div_start_o, bus.div_cancel_o}, 2'b00);

`ifdef DIV_CTRL_ZERO_TRAP_EN
    request(1'b0, 32'd5, 32'd0);
    @(negedge clk);
    bus.ex_div_i = 1'b0;
    #1 chk("zero_trap_pulse", bus.zero_trap_o, 1'b1);
    chk("zero_no_start", bus.div_start_o, 1'b0);
    chk("zero_no_stall", bus.stall_o, 1'b0);
    @(negedge clk);
    chk("zero_trap_end", bus.zero_trap_o, 1'b0);
    chk("zero_idle", bus.div_start_o, 1'b0);
`else
    run_div(1'b0, 32'd5, 32'd0, 3, 32'd0, 32'd0);
    chk("zero_trap_tied", bus.zero_trap_o, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
